// File: rtl/op_uram_readout_ctrl_if.sv
// Bundles the op URAM read port and the result stream seen by op_uram_readout_ctrl.
// master = the readout controller, slave = URAM bank / downstream stream consumer.
interface op_uram_readout_ctrl_if #(
  parameter int NUM_URAM        = 64,
  parameter int URAM_ADDR_WIDTH = 14,
  parameter int DATA_WIDTH      = 16
);
  logic [URAM_ADDR_WIDTH-1:0] op_uram_addrb;
  logic [NUM_URAM-1:0]        op_uram_enb;
  logic [NUM_URAM-1:0]        op_uram_doutb_valid;
  logic [DATA_WIDTH-1:0]      op_uram_doutb;
  logic [DATA_WIDTH-1:0]      m_tdata;
  logic                       m_tvalid;
  logic                       m_tready;
  logic                       m_tlast;

  modport master (
    output op_uram_addrb, op_uram_enb, op_uram_doutb_valid,
    output m_tdata, m_tvalid, m_tlast,
    input  op_uram_doutb, m_tready
  );

  modport slave (
    input  op_uram_addrb, op_uram_enb, op_uram_doutb_valid,
    input  m_tdata, m_tvalid, m_tlast,
    output op_uram_doutb, m_tready
  );
endinterface

// File: rtl/op_uram_readout_ctrl.sv
// Drains the op URAM bank after GeMM completion: credit-limited reads into a FWFT skid FIFO,
// streamed out with tlast. Define OPRD_STALL_STATS_EN to build the stall_cycles counter.
module op_uram_readout_ctrl #(
  parameter int NUM_URAM        = 64,
  parameter int URAM_ADDR_WIDTH = 14,
  parameter int RD_WORDS        = 16384,
  parameter int DATA_WIDTH      = 16,
  parameter int RD_LATENCY      = 3,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    done_in,
  op_uram_readout_ctrl_if.master  bus,
  output logic                    busy,
  output logic                    drain_done,
  output logic [31:0]             stall_cycles
);
  localparam int UW = (NUM_URAM > 1) ? $clog2(NUM_URAM) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic                       doneIn_q;
  logic [UW-1:0]              uCnt_q, uCnt_d;
  logic [URAM_ADDR_WIDTH-1:0] aCnt_q, aCnt_d;
  logic [URAM_ADDR_WIDTH-1:0] addr_q;
  logic [NUM_URAM-1:0]        enb_q;
  logic                       issVld_q, issLast_q;
  logic [UW-1:0]              issU_q;
  logic [RD_LATENCY-1:0]      srVld_q, srLast_q;
  logic [UW-1:0]              srU_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0]      memData_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]      memLast_q;
  logic [PW-1:0]              wrPtr_q, rdPtr_q;
  logic [CW-1:0]              fifoCount_q, inflight_q;
  logic [CW:0]                credit;
  logic                       arm, issue, issueLast, push, pop, lastAccept, fifoEmpty;

  assign arm        = done_in & ~doneIn_q & (state_q == IDLE);
  assign credit     = {1'b0, fifoCount_q} + {1'b0, inflight_q};
  assign issueLast  = (aCnt_q == URAM_ADDR_WIDTH'(RD_WORDS - 1)) && (uCnt_q == UW'(NUM_URAM - 1));
  assign issue      = (state_q == RUN) && (credit < (CW+1)'(FIFO_DEPTH));
  assign fifoEmpty  = (fifoCount_q == '0);
  assign push       = srVld_q[RD_LATENCY-1];
  assign pop        = ~fifoEmpty & bus.m_tready;
  assign lastAccept = pop & memLast_q[rdPtr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = RUN;
      RUN:     if (issue && issueLast) state_d = FLUSH;
      FLUSH:   if (lastAccept && (inflight_q == '0) && (fifoCount_q == CW'(1))) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Address outer, URAM inner; both wrap back to zero only once the final word is issued.
  always_comb begin
    uCnt_d = uCnt_q;
    aCnt_d = aCnt_q;
    if (arm || (issue && issueLast)) begin
      uCnt_d = '0;
      aCnt_d = '0;
    end else if (issue) begin
      if (uCnt_q == UW'(NUM_URAM - 1)) begin
        uCnt_d = '0;
        aCnt_d = aCnt_q + URAM_ADDR_WIDTH'(1);
      end else begin
        uCnt_d = uCnt_q + UW'(1);
      end
    end
  end

  // doneIn_q resets high so a done_in level already high at reset release does not arm a drain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      doneIn_q  <= 1'b1;
      uCnt_q    <= '0;
      aCnt_q    <= '0;
      addr_q    <= '0;
      enb_q     <= '0;
      issVld_q  <= 1'b0;
      issU_q    <= '0;
      issLast_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      doneIn_q  <= done_in;
      uCnt_q    <= uCnt_d;
      aCnt_q    <= aCnt_d;
      addr_q    <= issue ? aCnt_q : addr_q;
      enb_q     <= issue ? (NUM_URAM'(1) << uCnt_q) : '0;
      issVld_q  <= issue;
      issU_q    <= uCnt_q;
      issLast_q <= issue & issueLast;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srVld_q  <= '0;
      srLast_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) srU_q[i] <= '0;
    end else begin
      srVld_q[0]  <= issVld_q;
      srLast_q[0] <= issLast_q;
      srU_q[0]    <= issU_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        srVld_q[i]  <= srVld_q[i-1];
        srLast_q[i] <= srLast_q[i-1];
        srU_q[i]    <= srU_q[i-1];
      end
    end
  end

  // Every read holds a credit from issue until it is popped, so a push never meets a full FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoCount_q <= '0;
      inflight_q  <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      case ({push, pop})
        2'b10:   fifoCount_q <= fifoCount_q + CW'(1);
        2'b01:   fifoCount_q <= fifoCount_q - CW'(1);
        default: fifoCount_q <= fifoCount_q;
      endcase
      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      memData_q[wrPtr_q] <= bus.op_uram_doutb;
      memLast_q[wrPtr_q] <= srLast_q[RD_LATENCY-1];
    end
  end

  assign bus.op_uram_addrb       = addr_q;
  assign bus.op_uram_enb         = enb_q;
  assign bus.op_uram_doutb_valid = push ? (NUM_URAM'(1) << srU_q[RD_LATENCY-1]) : '0;
  assign bus.m_tvalid            = ~fifoEmpty;
  assign bus.m_tdata             = fifoEmpty ? '0 : memData_q[rdPtr_q];
  assign bus.m_tlast             = ~fifoEmpty & memLast_q[rdPtr_q];
  assign busy                    = (state_q != IDLE);
  assign drain_done              = (state_q == DONE);

`ifdef OPRD_STALL_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (arm) begin
      stall_q <= '0;
    end else if (busy && bus.m_tvalid && !bus.m_tready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_op_uram_readout_ctrl.sv
// Bench for op_uram_readout_ctrl: URAM model returns (u<<8)|a, stream checked against word-index order.
module tb_op_uram_readout_ctrl;
   localparam int N     = 4;
   localparam int RW    = 4;
   localparam int AW    = 14;
   localparam int DW    = 16;
   localparam int L     = 3;
   localparam int FD    = 8;
   localparam int TOTAL = N * RW;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        done_in;
   logic        busy;
   logic        drain_done;
   logic [31:0] stall_cycles;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int issueIdx, acceptIdx, dones, doneCyc, firstIssueCyc, stallModel;
   bit monitorEn = 1'b0;
   bit lastHsPrev = 1'b0;
   int k;

   logic          uramVld [L];
   int            uramU [L];
   int            uramA [L];
   logic [DW-1:0] garbage;

   op_uram_readout_ctrl_if #(.NUM_URAM(N), .URAM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   op_uram_readout_ctrl #(
      .NUM_URAM(N), .URAM_ADDR_WIDTH(AW), .RD_WORDS(RW),
      .DATA_WIDTH(DW), .RD_LATENCY(L), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .done_in(done_in),
      .bus(bus),
      .busy(busy),
      .drain_done(drain_done),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic int oneHotIdx(input logic [N-1:0] v);
      int r = 0;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Word w lives in URAM w%N at address w/N.
   function automatic logic [31:0] expData(input int w);
      return 32'(((w % N) << 8) | (w / N));
   endfunction

   // URAM bank model: read data appears L cycles after the enable cycle, garbage otherwise.
   always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) begin
         uramVld[i] <= uramVld[i-1];
         uramU[i]   <= uramU[i-1];
         uramA[i]   <= uramA[i-1];
      end
      uramVld[0] <= (bus.op_uram_enb != '0);
      uramU[0]   <= oneHotIdx(bus.op_uram_enb);
      uramA[0]   <= int'(bus.op_uram_addrb);
      garbage    <= DW'($urandom);
   end

   assign bus.op_uram_doutb = uramVld[L-1] ? DW'((uramU[L-1] << 8) | uramA[L-1]) : garbage;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic rdy, input logic dn);
      @(posedge clk);
      #1;
      bus.m_tready = rdy;
      done_in      = dn;
   endtask

   task automatic initDrain();
      issueIdx      = 0;
      acceptIdx     = 0;
      dones         = 0;
      doneCyc       = -1;
      firstIssueCyc = -1;
      stallModel    = 0;
      lastHsPrev    = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_addrb"}, 32'(bus.op_uram_addrb), 32'd0);
      checkOutput({tag, "_enb"}, 32'(bus.op_uram_enb), 32'd0);
      checkOutput({tag, "_dvalid"}, 32'(bus.op_uram_doutb_valid), 32'd0);
      checkOutput({tag, "_tdata"}, 32'(bus.m_tdata), 32'd0);
      checkOutput({tag, "_tvalid"}, 32'(bus.m_tvalid), 32'd0);
      checkOutput({tag, "_tlast"}, 32'(bus.m_tlast), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_drain_done"}, 32'(drain_done), 32'd0);
      checkOutput({tag, "_stall"}, stall_cycles, 32'd0);
   endtask

   task automatic checkStall(input string tag);
`ifdef OPRD_STALL_STATS_EN
      checkOutput(tag, stall_cycles, 32'(stallModel));
`else
      checkOutput(tag, stall_cycles, 32'd0);
`endif
   endtask

   // Cycle monitor: issue order, credit bound, return alignment, stream order and done timing.
   always @(negedge clk) begin
      if (monitorEn) begin
         if (bus.op_uram_enb != '0) begin
            checkOutput("enb_order", 32'(bus.op_uram_enb), 32'd1 << (issueIdx % N));
            checkOutput("addr_order", 32'(bus.op_uram_addrb), 32'(issueIdx / N));
            if (issueIdx == 0) firstIssueCyc = cyc;
            issueIdx++;
         end
         checkOutput("credit_bound", 32'((issueIdx - acceptIdx) <= FD), 32'd1);
         checkOutput("doutb_valid", 32'(bus.op_uram_doutb_valid),
                     uramVld[L-1] ? (32'd1 << uramU[L-1]) : 32'd0);
         if (bus.m_tvalid) begin
            checkOutput("tdata", 32'(bus.m_tdata), expData(acceptIdx));
            checkOutput("tlast", 32'(bus.m_tlast), 32'(acceptIdx == TOTAL - 1));
         end
         checkOutput("drain_done_timing", 32'(drain_done), 32'(lastHsPrev));
         if (drain_done) begin
            dones++;
            doneCyc = cyc;
         end
         if (bus.m_tvalid && !bus.m_tready && busy) stallModel++;
         lastHsPrev = bus.m_tvalid && bus.m_tready && bus.m_tlast;
         if (bus.m_tvalid && bus.m_tready) acceptIdx++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset_n      = 1'b0;
      done_in      = 1'b0;
      bus.m_tready = 1'b0;
      initDrain();
      repeat (3) @(posedge clk);
      #1;
      checkAllZero("reset");
      reset_n = 1'b1;
      repeat (4) applyStimulus(1'b1, 1'b0);
      monitorEn = 1'b1;

      // Basic drain with ready held high
      $display("[TB] basic drain");
      initDrain();
      applyStimulus(1'b1, 1'b1);
      k = cyc + 1;
      for (int i = 0; i < 200 && dones == 0; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("basic_done_seen", 32'(dones), 32'd1);
      checkOutput("basic_words", 32'(acceptIdx), 32'(TOTAL));
      checkOutput("basic_first_enb_cycle", 32'(firstIssueCyc), 32'(k + 1));
      checkOutput("basic_done_cycle", 32'(doneCyc), 32'(k + 21));
      checkOutput("basic_busy_after", 32'(busy), 32'd0);
      checkStall("basic_stall");

      // Ready pattern 1,0,0,1
      $display("[TB] backpressure pattern");
      initDrain();
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 400 && dones == 0; i++)
         applyStimulus((i % 4 == 0) || (i % 4 == 3), 1'b0);
      checkOutput("bp_done_seen", 32'(dones), 32'd1);
      checkOutput("bp_words", 32'(acceptIdx), 32'(TOTAL));
      checkStall("bp_stall");

      // Ready low from the start for 20 cycles
      $display("[TB] ready held low");
      initDrain();
      applyStimulus(1'b0, 1'b1);
      repeat (20) applyStimulus(1'b0, 1'b0);
      checkOutput("stall_issues", 32'(issueIdx), 32'(FD));
      checkOutput("stall_accepts", 32'(acceptIdx), 32'd0);
      checkOutput("stall_tvalid", 32'(bus.m_tvalid), 32'd1);
      checkOutput("stall_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 200 && dones == 0; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("stall_done_seen", 32'(dones), 32'd1);
      checkOutput("stall_words", 32'(acceptIdx), 32'(TOTAL));
      checkStall("stall_stall");

      // Random ready with done_in re-pulsed during RUN
      $display("[TB] random ready with re-pulse");
      initDrain();
      applyStimulus(1'($urandom_range(0, 1)), 1'b1);
      for (int i = 0; i < 400 && dones == 0; i++)
         applyStimulus(1'($urandom_range(0, 1)), (i >= 4) && (i < 8));
      repeat (10) applyStimulus(1'($urandom_range(0, 1)), 1'b0);
      checkOutput("repulse_dones", 32'(dones), 32'd1);
      checkOutput("repulse_words", 32'(acceptIdx), 32'(TOTAL));
      checkOutput("repulse_busy", 32'(busy), 32'd0);
      checkStall("repulse_stall");

      // Reset asserted mid-drain at word 7
      $display("[TB] reset mid-drain");
      initDrain();
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 100 && acceptIdx < 7; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("rst_reached_word7", 32'(acceptIdx >= 7), 32'd1);
      monitorEn = 1'b0;
      done_in   = 1'b1;
      reset_n   = 1'b0;
      #2;
      checkAllZero("rst_mid");
      repeat (3) applyStimulus(1'b1, 1'b1);
      reset_n = 1'b1;
      repeat (5) applyStimulus(1'b1, 1'b1);
      initDrain();
      monitorEn = 1'b1;
      repeat (10) applyStimulus(1'b1, 1'b1);
      checkOutput("rst_no_rearm_issues", 32'(issueIdx), 32'd0);
      checkOutput("rst_no_rearm_busy", 32'(busy), 32'd0);
      checkOutput("rst_no_rearm_dones", 32'(dones), 32'd0);
      repeat (2) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 200 && dones == 0; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("rst_redrain_dones", 32'(dones), 32'd1);
      checkOutput("rst_redrain_words", 32'(acceptIdx), 32'(TOTAL));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
